// File: rtl/microcode_sequencer.sv
// rtl/microcode_sequencer.sv - microcode ROM address sequencer (entry point, NEXT/JUMP/BRANCH/END, wait stalls)
// Optional retire-count watchdog enabled by defining UCODE_WATCHDOG_EN.
module microcode_sequencer #(
  parameter int UADDR_W     = 8,
  parameter int UINSTR_W    = 32,
  parameter int OPCODE_W    = 8,
  parameter int ENTRY_SHIFT = 2
`ifdef UCODE_WATCHDOG_EN
  ,
  parameter int MAX_STEPS   = 64
`endif
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  op_valid_i,
  output logic                  op_ready_o,
  input  logic [OPCODE_W-1:0]   opcode_i,
  input  logic                  abort_i,
  output logic [UADDR_W-1:0]    uaddr_o,
  input  logic [UINSTR_W-1:0]   uinstr_i,
  input  logic                  cond_i,
  input  logic                  mem_ready_i,
  output logic                  ctrl_valid_o,
  output logic [UINSTR_W-12:0]  ctrl_o,
  output logic                  done_o,
  output logic                  busy_o,
  output logic                  err_o
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_STALL = 2'd2
  } state_t;

  localparam logic [1:0] SEQ_NEXT   = 2'b00;
  localparam logic [1:0] SEQ_JUMP   = 2'b01;
  localparam logic [1:0] SEQ_BRANCH = 2'b10;
  localparam logic [1:0] SEQ_END    = 2'b11;

  localparam int ENTRY_W = OPCODE_W + ENTRY_SHIFT + UADDR_W;

  state_t               r_state;
  state_t               w_state_nxt;
  logic [UADDR_W-1:0]   r_uaddr;
  logic [UADDR_W-1:0]   w_uaddr_nxt;
  logic [UADDR_W-1:0]   w_uaddr_inc;
  logic [UADDR_W-1:0]   w_target;
  logic [UADDR_W-1:0]   w_entry;
  logic [ENTRY_W-1:0]   w_entry_wide;
  logic                 w_unused_entry_hi;
  logic [1:0]           w_seq;
  logic                 w_wait;
  logic                 w_active;
  logic                 w_retire;
  logic                 w_accept;
  logic                 w_is_end;
  logic                 w_wdog_hit;

  // Entry point is computed wide so the shifted-out opcode bits are dropped explicitly.
  assign w_entry_wide      = {{(ENTRY_SHIFT + UADDR_W){1'b0}}, opcode_i} << ENTRY_SHIFT;
  assign w_entry           = w_entry_wide[UADDR_W-1:0];
  assign w_unused_entry_hi = ^w_entry_wide[ENTRY_W-1:UADDR_W];

  assign w_target    = uinstr_i[UADDR_W-1:0];
  assign w_seq       = uinstr_i[9:8];
  assign w_wait      = uinstr_i[10];
  assign w_uaddr_inc = r_uaddr + 1'b1;

  assign w_active = (r_state != S_IDLE);
  assign w_accept = (r_state == S_IDLE) && op_valid_i;
  assign w_retire = w_active && !abort_i && (!w_wait || mem_ready_i);
  assign w_is_end = (w_seq == SEQ_END);

`ifdef UCODE_WATCHDOG_EN
  localparam int STEP_W = $clog2(MAX_STEPS + 1);
  localparam logic [STEP_W-1:0] LAST_STEP = STEP_W'(MAX_STEPS - 1);

  logic [STEP_W-1:0] r_steps;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_steps <= '0;
    end else if (w_accept) begin
      r_steps <= '0;
    end else if (w_retire) begin
      r_steps <= r_steps + 1'b1;
    end
  end

  assign w_wdog_hit = w_retire && !w_is_end && (r_steps == LAST_STEP);
`else
  assign w_wdog_hit = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_uaddr <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_uaddr <= w_uaddr_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_uaddr_nxt = r_uaddr;
    case (r_state)
      S_IDLE: begin
        if (op_valid_i) begin
          w_uaddr_nxt = w_entry;
          w_state_nxt = S_RUN;
        end
      end
      S_RUN, S_STALL: begin
        if (abort_i) begin
          w_state_nxt = S_IDLE;
        end else if (!w_retire) begin
          w_state_nxt = S_STALL;
        end else if (w_wdog_hit) begin
          w_state_nxt = S_IDLE;
        end else begin
          w_state_nxt = S_RUN;
          case (w_seq)
            SEQ_NEXT:   w_uaddr_nxt = w_uaddr_inc;
            SEQ_JUMP:   w_uaddr_nxt = w_target;
            SEQ_BRANCH: w_uaddr_nxt = cond_i ? w_target : w_uaddr_inc;
            default:    w_state_nxt = S_IDLE;
          endcase
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  assign op_ready_o   = (r_state == S_IDLE);
  assign busy_o       = w_active;
  assign uaddr_o      = r_uaddr;
  assign ctrl_valid_o = w_retire;
  assign ctrl_o       = w_retire ? uinstr_i[UINSTR_W-1:11] : '0;
  assign done_o       = w_retire && w_is_end;
  assign err_o        = w_wdog_hit;

endmodule

// File: tb/tb_microcode_sequencer.sv
// tb/tb_microcode_sequencer.sv - directed vector bench for microcode_sequencer
// Watchdog checks follow UCODE_WATCHDOG_EN.
module tb_microcode_sequencer;

  logic        clk;
  logic        rst;
  logic        op_valid_i;
  logic        op_ready_o;
  logic [7:0]  opcode_i;
  logic        abort_i;
  logic [7:0]  uaddr_o;
  logic [31:0] uinstr_i;
  logic        cond_i;
  logic        mem_ready_i;
  logic        ctrl_valid_o;
  logic [20:0] ctrl_o;
  logic        done_o;
  logic        busy_o;
  logic        err_o;

  logic [31:0] rom [256];

  int n_checks;
  int n_fail;

  microcode_sequencer dut (
    .clk         (clk),
    .rst         (rst),
    .op_valid_i  (op_valid_i),
    .op_ready_o  (op_ready_o),
    .opcode_i    (opcode_i),
    .abort_i     (abort_i),
    .uaddr_o     (uaddr_o),
    .uinstr_i    (uinstr_i),
    .cond_i      (cond_i),
    .mem_ready_i (mem_ready_i),
    .ctrl_valid_o(ctrl_valid_o),
    .ctrl_o      (ctrl_o),
    .done_o      (done_o),
    .busy_o      (busy_o),
    .err_o       (err_o)
  );

  assign uinstr_i = rom[uaddr_o];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        op_valid;
    logic [7:0]  opcode;
    logic        abort;
    logic        cond;
    logic        mem_ready;
    logic [7:0]  e_uaddr;
    logic        e_valid;
    logic [20:0] e_ctrl;
    logic        e_done;
    logic        e_ready;
    logic        e_busy;
  } vec_t;

  vec_t vecs [$];

  function automatic logic [31:0] mk(input logic [20:0] c, input logic w,
                                     input logic [1:0] s, input logic [7:0] t);
    return {c, w, s, t};
  endfunction

  function automatic vec_t v(input logic ov, input logic [7:0] op, input logic ab,
                             input logic cd, input logic mr, input logic [7:0] ua,
                             input logic vl, input logic [20:0] ct, input logic dn,
                             input logic rd, input logic bs);
    vec_t r;
    r.op_valid = ov; r.opcode = op; r.abort = ab; r.cond = cd; r.mem_ready = mr;
    r.e_uaddr = ua; r.e_valid = vl; r.e_ctrl = ct; r.e_done = dn;
    r.e_ready = rd; r.e_busy = bs;
    return r;
  endfunction

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  // Packed snapshot: {uaddr, valid, ctrl, done, ready, busy, err}
  function automatic logic [63:0] snap();
    return {30'd0, uaddr_o, ctrl_valid_o, ctrl_o, done_o, op_ready_o, busy_o, err_o};
  endfunction

  function automatic logic [63:0] want(input logic [7:0] ua, input logic vl,
                                       input logic [20:0] ct, input logic dn,
                                       input logic rd, input logic bs, input logic er);
    return {30'd0, ua, vl, ct, dn, rd, bs, er};
  endfunction

  initial begin
    n_checks = 0;
    n_fail   = 0;
    for (int i = 0; i < 256; i++) rom[i] = 32'd0;
    rom[8'h00] = mk(21'h01001, 1'b0, 2'b00, 8'h00);
    rom[8'h01] = mk(21'h01002, 1'b0, 2'b00, 8'h00);
    rom[8'h02] = mk(21'h01003, 1'b0, 2'b00, 8'h00);
    rom[8'h03] = mk(21'h01004, 1'b0, 2'b11, 8'h00);
    rom[8'h10] = mk(21'h02010, 1'b0, 2'b10, 8'h20);
    rom[8'h11] = mk(21'h02011, 1'b0, 2'b11, 8'h00);
    rom[8'h20] = mk(21'h02020, 1'b0, 2'b11, 8'h00);
    rom[8'h40] = mk(21'h00040, 1'b0, 2'b01, 8'h40);
    rom[8'hFC] = mk(21'h003FC, 1'b0, 2'b01, 8'hFF);
    rom[8'hFF] = mk(21'h003FF, 1'b1, 2'b00, 8'h00);

    //          ov  op     ab  cd  mr  uaddr  vl  ctrl       dn  rd  bs
    vecs.push_back(v(0, 8'h00, 0, 0, 1, 8'h00, 0, 21'h0,     0, 1, 0));
    vecs.push_back(v(1, 8'h00, 0, 0, 1, 8'h00, 0, 21'h0,     0, 1, 0));
    vecs.push_back(v(1, 8'h55, 0, 0, 1, 8'h00, 1, 21'h01001, 0, 0, 1));
    vecs.push_back(v(0, 8'h00, 0, 0, 1, 8'h01, 1, 21'h01002, 0, 0, 1));
    vecs.push_back(v(0, 8'h00, 0, 0, 1, 8'h02, 1, 21'h01003, 0, 0, 1));
    vecs.push_back(v(0, 8'h00, 0, 0, 1, 8'h03, 1, 21'h01004, 1, 0, 1));
    vecs.push_back(v(1, 8'h04, 0, 0, 1, 8'h03, 0, 21'h0,     0, 1, 0));
    vecs.push_back(v(0, 8'h00, 0, 1, 1, 8'h10, 1, 21'h02010, 0, 0, 1));
    vecs.push_back(v(0, 8'h00, 0, 0, 1, 8'h20, 1, 21'h02020, 1, 0, 1));
    vecs.push_back(v(1, 8'h04, 0, 0, 1, 8'h20, 0, 21'h0,     0, 1, 0));
    vecs.push_back(v(0, 8'h00, 0, 0, 1, 8'h10, 1, 21'h02010, 0, 0, 1));
    vecs.push_back(v(0, 8'h00, 0, 0, 1, 8'h11, 1, 21'h02011, 1, 0, 1));
    vecs.push_back(v(1, 8'hFF, 0, 0, 1, 8'h11, 0, 21'h0,     0, 1, 0));
    vecs.push_back(v(0, 8'h00, 0, 0, 0, 8'hFC, 1, 21'h003FC, 0, 0, 1));
    vecs.push_back(v(0, 8'h00, 0, 0, 0, 8'hFF, 0, 21'h0,     0, 0, 1));
    vecs.push_back(v(0, 8'h00, 0, 1, 0, 8'hFF, 0, 21'h0,     0, 0, 1));
    vecs.push_back(v(1, 8'h04, 0, 0, 0, 8'hFF, 0, 21'h0,     0, 0, 1));
    vecs.push_back(v(0, 8'h00, 0, 0, 1, 8'hFF, 1, 21'h003FF, 0, 0, 1));
    vecs.push_back(v(0, 8'h00, 0, 0, 1, 8'h00, 1, 21'h01001, 0, 0, 1));
    vecs.push_back(v(0, 8'h00, 0, 0, 1, 8'h01, 1, 21'h01002, 0, 0, 1));
    vecs.push_back(v(0, 8'h00, 0, 0, 1, 8'h02, 1, 21'h01003, 0, 0, 1));
    vecs.push_back(v(0, 8'h00, 1, 0, 1, 8'h03, 0, 21'h0,     0, 0, 1));
    vecs.push_back(v(0, 8'h00, 1, 0, 1, 8'h03, 0, 21'h0,     0, 1, 0));
    vecs.push_back(v(1, 8'h00, 1, 0, 1, 8'h03, 0, 21'h0,     0, 1, 0));
    vecs.push_back(v(0, 8'h00, 0, 0, 1, 8'h00, 1, 21'h01001, 0, 0, 1));

    rst = 1'b1; op_valid_i = 1'b0; opcode_i = 8'h00; abort_i = 1'b0;
    cond_i = 1'b0; mem_ready_i = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < vecs.size(); i++) begin
      if (i != 0) @(negedge clk);
      op_valid_i  = vecs[i].op_valid;
      opcode_i    = vecs[i].opcode;
      abort_i     = vecs[i].abort;
      cond_i      = vecs[i].cond;
      mem_ready_i = vecs[i].mem_ready;
      #1;
      check($sformatf("vec%0d", i), snap(),
            want(vecs[i].e_uaddr, vecs[i].e_valid, vecs[i].e_ctrl, vecs[i].e_done,
                 vecs[i].e_ready, vecs[i].e_busy, 1'b0));
    end

    // Reset in the middle of a sequence (sequencer now at 0x01).
    @(negedge clk);
    op_valid_i = 1'b0; abort_i = 1'b0; mem_ready_i = 1'b1; rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("rst_mid", snap(), want(8'h00, 1'b0, 21'h0, 1'b0, 1'b1, 1'b0, 1'b0));

    // JUMP-to-self loop at 0x40 (opcode 0x10).
    @(negedge clk);
    op_valid_i = 1'b1; opcode_i = 8'h10;
    #1;
    check("loop_accept", snap(), want(8'h00, 1'b0, 21'h0, 1'b0, 1'b1, 1'b0, 1'b0));
`ifdef UCODE_WATCHDOG_EN
    for (int k = 1; k <= 64; k++) begin
      @(negedge clk);
      op_valid_i = 1'b0;
      #1;
      check($sformatf("wdog_step%0d", k), snap(),
            want(8'h40, 1'b1, 21'h00040, 1'b0, 1'b0, 1'b1, (k == 64)));
    end
    @(negedge clk);
    #1;
    check("wdog_idle", snap(), want(8'h40, 1'b0, 21'h0, 1'b0, 1'b1, 1'b0, 1'b0));
`else
    for (int k = 1; k <= 200; k++) begin
      @(negedge clk);
      op_valid_i = 1'b0;
      #1;
      check($sformatf("loop_step%0d", k), snap(),
            want(8'h40, 1'b1, 21'h00040, 1'b0, 1'b0, 1'b1, 1'b0));
    end
    @(negedge clk);
    abort_i = 1'b1;
    #1;
    check("loop_abort", snap(), want(8'h40, 1'b0, 21'h0, 1'b0, 1'b0, 1'b1, 1'b0));
    @(negedge clk);
    abort_i = 1'b0;
    #1;
    check("loop_idle", snap(), want(8'h40, 1'b0, 21'h0, 1'b0, 1'b1, 1'b0, 1'b0));
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
